// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state encoding for seq_alu.
package alu_pkg;

    localparam int OP_NOT  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_AND  = 2;
    localparam int OP_XOR  = 3;
    localparam int OP_SHR  = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_ROR  = 6;
    localparam int OP_ROL  = 7;
    localparam int OP_INC  = 8;
    localparam int OP_DEC  = 9;
    localparam int OP_ADD  = 10;
    localparam int OP_ADDC = 11;
    localparam int OP_SUB  = 12;
    localparam int OP_SUBC = 13;
    localparam int OP_CMP  = 14;
    localparam int OP_MUL  = 15;
    localparam int OP_DIV  = 16;

    localparam int F_Z = 0;
    localparam int F_N = 1;
    localparam int F_C = 2;
    localparam int F_O = 3;
    localparam int F_D = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input int opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// done is high during the final iteration; lo/hi carry that iteration's next values.
module seq_muldiv #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q;
    logic             div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] mcand_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // hi:lo is the partial product (multiplier in lo) or remainder:dividend/quotient.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hi_n    = hi_q;
        lo_n    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, mcand_q};
        diff    = shifted[WIDTH-1:0] - mcand_q;
        if (div_q) begin
            hi_n = ge ? diff : shifted[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (count_q == CW'(WIDTH - 1));
    assign lo   = lo_n;
    assign hi   = hi_n;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
        if (rst) begin
            busy_q  <= 1'b0;
            div_q   <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            div_q   <= is_div;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= is_div ? a : b;
            mcand_q <= is_div ? b : a;
        end else if (busy_q) begin
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            count_q <= count_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/arith ops, iterative MUL/DIV,
// valid/ready handshakes on request and result sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } req_t;

    localparam logic [WIDTH-1:0] WIDTH_U = WIDTH'(WIDTH);

    state_t           state;
    req_t             req_q;
    req_t             cur;
    int               op_i;
    logic [WIDTH-1:0] res_q, hi_q;
    logic [4:0]       flags_q;

    logic [WIDTH-1:0]   alu_res, alu_hi, zn_src, y, amt;
    logic [4:0]         alu_flags;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] rot;
    logic               carry_in, c, o, d, defined;

    logic             iterative, md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [4:0]       md_flags;

    // Live request while IDLE, the captured one afterwards, so later input changes are invisible.
    assign cur  = (state == ST_IDLE) ? req_t'{op: op, a: a, b: b, cin: cin} : req_q;
    assign op_i = int'(cur.op);

    always_comb begin
        alu_res  = '0;
        alu_hi   = '0;
        zn_src   = '0;
        y        = '0;
        carry_in = 1'b0;
        sum      = '0;
        diff     = '0;
        rot      = '0;
        c        = 1'b0;
        o        = 1'b0;
        d        = 1'b0;
        defined  = 1'b1;
        amt      = cur.b % WIDTH_U;
        case (op_i)
            OP_NOT: alu_res = ~cur.a;
            OP_OR:  alu_res = cur.a | cur.b;
            OP_AND: alu_res = cur.a & cur.b;
            OP_XOR: alu_res = cur.a ^ cur.b;
            OP_SHR: alu_res = (cur.b >= WIDTH_U) ? '0 : cur.a >> cur.b;
            OP_SHL: alu_res = (cur.b >= WIDTH_U) ? '0 : cur.a << cur.b;
            OP_ROR: begin
                rot     = {cur.a, cur.a} >> amt;
                alu_res = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot     = {cur.a, cur.a} << amt;
                alu_res = rot[2*WIDTH-1:WIDTH];
            end
            OP_INC, OP_ADD, OP_ADDC: begin
                y        = (op_i == OP_INC) ? '0 : cur.b;
                carry_in = (op_i == OP_INC) || ((op_i == OP_ADDC) && cur.cin);
                sum      = {1'b0, cur.a} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
                alu_res  = sum[WIDTH-1:0];
                c        = sum[WIDTH];
                o        = (cur.a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != cur.a[WIDTH-1]);
            end
            OP_DEC, OP_SUB, OP_SUBC, OP_CMP: begin
                y        = (op_i == OP_DEC) ? '0 : cur.b;
                carry_in = (op_i == OP_DEC) || ((op_i == OP_SUBC) && cur.cin);
                diff     = {1'b0, cur.a} - {1'b0, y} - {{WIDTH{1'b0}}, carry_in};
                alu_res  = (op_i == OP_CMP) ? '0 : diff[WIDTH-1:0];
                c        = diff[WIDTH];
                o        = (cur.a[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != cur.a[WIDTH-1]);
            end
            // Only divide-by-zero completes here; nonzero divisors go to seq_muldiv.
            OP_DIV: begin
                alu_res = '1;
                alu_hi  = cur.a;
                d       = 1'b1;
            end
            default: defined = 1'b0;
        endcase
        zn_src = (op_i == OP_CMP) ? diff[WIDTH-1:0] : alu_res;
        alu_flags = '0;
        if (defined) begin
            alu_flags[F_Z] = (zn_src == '0);
            alu_flags[F_N] = zn_src[WIDTH-1];
            alu_flags[F_C] = c;
            alu_flags[F_O] = o;
            alu_flags[F_D] = d;
        end
    end

    assign iterative = is_iterative(op_i) && !((op_i == OP_DIV) && (cur.b == '0));
    assign md_start  = (state == ST_IDLE) && in_valid && iterative && !rst;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (op_i == OP_DIV),
        .a      (cur.a),
        .b      (cur.b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_comb begin
        md_flags      = '0;
        md_flags[F_Z] = (md_lo == '0);
        md_flags[F_N] = md_lo[WIDTH-1];
        md_flags[F_C] = (int'(req_q.op) == OP_MUL) && (md_hi != '0);
        md_flags[F_O] = md_flags[F_C];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        req_q <= cur;
                        if (iterative) begin
                            state <= ST_BUSY;
                        end else begin
                            res_q   <= alu_res;
                            hi_q    <= alu_hi;
                            flags_q <= alu_flags;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        res_q   <= md_lo;
                        hi_q    <= md_hi;
                        flags_q <= md_flags;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE) && !rst;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=20: vector table plus handshake/reset sequences.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [19:0] a = '0;
    logic [19:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] result;
    logic [19:0] result_hi;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          op;
        logic [19:0] a;
        logic [19:0] b;
        logic        cin;
        logic [19:0] res;
        logic [19:0] hi;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(20), .OPW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 1);
        op = 5'(v.op); a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); a = 20'($urandom); b = 20'($urandom); cin = ~cin;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " result_hi"}, 32'(result_hi), 32'(v.hi));
        check({tag, " flags"}, 32'(flags), 32'(v.fl));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire"}, 32'({in_ready, out_valid}), 32'(2'b10));
    endtask

    initial begin
        vec_t rol_v;
        rol_v = '{OP_ROL, 20'h80001, 20'd21, 1'b0, 20'h00003, 20'h0, 5'h00, 1};

        // flags column is {D,O,C,N,Z}
        vecs.push_back('{OP_ADD,  20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 20'h0,     5'h05, 1});
        vecs.push_back('{OP_SUB,  20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 20'h0,     5'h08, 1});
        vecs.push_back('{OP_CMP,  20'h00003, 20'h00005, 1'b0, 20'h00000, 20'h0,     5'h06, 1});
        vecs.push_back('{OP_MUL,  20'h12345, 20'h00100, 1'b0, 20'h34500, 20'h00012, 5'h0C, 21});
        vecs.push_back('{OP_DIV,  20'd100,   20'd7,     1'b0, 20'd14,    20'd2,     5'h00, 21});
        vecs.push_back('{OP_DIV,  20'd5,     20'd0,     1'b0, 20'hFFFFF, 20'd5,     5'h12, 1});
        vecs.push_back('{OP_NOT,  20'h0F0F0, 20'h00000, 1'b0, 20'hF0F0F, 20'h0,     5'h02, 1});
        vecs.push_back('{OP_OR,   20'h00F00, 20'h0000F, 1'b0, 20'h00F0F, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_AND,  20'hFF00F, 20'h0F0F0, 1'b0, 20'h0F000, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_XOR,  20'h12345, 20'h12345, 1'b0, 20'h00000, 20'h0,     5'h01, 1});
        vecs.push_back('{OP_SHR,  20'h80000, 20'd19,    1'b0, 20'h00001, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_SHR,  20'hFFFFF, 20'd20,    1'b0, 20'h00000, 20'h0,     5'h01, 1});
        vecs.push_back('{OP_SHL,  20'h00001, 20'd19,    1'b0, 20'h80000, 20'h0,     5'h02, 1});
        vecs.push_back('{OP_SHL,  20'hFFFFF, 20'd25,    1'b0, 20'h00000, 20'h0,     5'h01, 1});
        vecs.push_back('{OP_ROR,  20'h00001, 20'd1,     1'b0, 20'h80000, 20'h0,     5'h02, 1});
        vecs.push_back('{OP_ROR,  20'h12345, 20'd0,     1'b0, 20'h12345, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_ROR,  20'h12345, 20'd20,    1'b0, 20'h12345, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_INC,  20'h7FFFF, 20'h00000, 1'b0, 20'h80000, 20'h0,     5'h0A, 1});
        vecs.push_back('{OP_INC,  20'hFFFFF, 20'h00000, 1'b0, 20'h00000, 20'h0,     5'h05, 1});
        vecs.push_back('{OP_DEC,  20'h00000, 20'h00000, 1'b0, 20'hFFFFF, 20'h0,     5'h06, 1});
        vecs.push_back('{OP_DEC,  20'h80000, 20'h00000, 1'b0, 20'h7FFFF, 20'h0,     5'h08, 1});
        vecs.push_back('{OP_ADDC, 20'h7FFFF, 20'h00000, 1'b1, 20'h80000, 20'h0,     5'h0A, 1});
        vecs.push_back('{OP_ADDC, 20'h00001, 20'h00002, 1'b1, 20'h00004, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_SUBC, 20'h00005, 20'h00003, 1'b1, 20'h00001, 20'h0,     5'h00, 1});
        vecs.push_back('{OP_SUBC, 20'h00003, 20'h00003, 1'b1, 20'hFFFFF, 20'h0,     5'h06, 1});
        vecs.push_back('{OP_CMP,  20'h00007, 20'h00007, 1'b0, 20'h00000, 20'h0,     5'h01, 1});
        vecs.push_back('{OP_CMP,  20'h80000, 20'h00001, 1'b0, 20'h00000, 20'h0,     5'h08, 1});
        vecs.push_back('{OP_MUL,  20'hFFFFF, 20'hFFFFF, 1'b0, 20'h00001, 20'hFFFFE, 5'h0C, 21});
        vecs.push_back('{OP_MUL,  20'h00003, 20'h00005, 1'b0, 20'h0000F, 20'h0,     5'h00, 21});
        vecs.push_back('{OP_DIV,  20'hFFFFF, 20'h00001, 1'b0, 20'hFFFFF, 20'h0,     5'h02, 21});
        vecs.push_back('{OP_DIV,  20'h00003, 20'd10,    1'b0, 20'h00000, 20'h00003, 5'h01, 21});
        vecs.push_back('{31,      20'h00005, 20'h00005, 1'b0, 20'h00000, 20'h0,     5'h00, 1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst result", 32'(result), 0);
        check("rst result_hi", 32'(result_hi), 0);
        check("rst flags", 32'(flags), 0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 1);

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 10 cycles, requests in DONE ignored
        op = 5'(OP_ADD); a = 20'd1; b = 20'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'(OP_XOR); a = 20'h5A5A5; b = 20'h00F00;
        check("bp out_valid", 32'(out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d result", k), 32'(result), 3);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 0);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", 32'({in_ready, out_valid}), 32'(2'b10));

        // Reset during BUSY cycle 7 of a MUL, with a stale nonzero result held
        run_vec(rol_v, "rol pre");
        op = 5'(OP_MUL); a = 20'h12345; b = 20'h00100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mul busy7 out_valid", 32'(out_valid), 0);
        check("mul busy7 in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("rst-in-busy handshakes", 32'({in_ready, out_valid}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst-in-busy in_ready", 32'(in_ready), 1);
        check("rst-in-busy result", 32'(result), 0);
        check("rst-in-busy result_hi", 32'(result_hi), 0);
        check("rst-in-busy flags", 32'(flags), 0);
        repeat (30) @(posedge clk);
        #1;
        check("rst-in-busy no late done", 32'(out_valid), 0);
        run_vec(rol_v, "rol post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
